// File: rtl/video_resync_ctrl.sv
// HDMI timing generator resync sequencer: qualify mode, configure, align, lock.
// Optional: VIDEO_RESYNC_FORWARD_EN forwards every vreset_in while locked.
module video_resync_ctrl #(
  parameter int unsigned STABLE_FRAMES  = 4,
  parameter int unsigned TIMEOUT_FRAMES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] mode_in,
  input  logic       vreset_in,
  input  logic       frame_tick,
  output logic [1:0] cfg_mode,
  output logic       cfg_valid,
  input  logic       cfg_ready,
  output logic       hdmi_vreset,
  output logic       locked,
  output logic [7:0] resync_count
);

  localparam logic [3:0] SF = 4'(STABLE_FRAMES);
  localparam logic [3:0] TF = 4'(TIMEOUT_FRAMES);

  typedef enum logic [1:0] {
    S_QUAL,
    S_CFG,
    S_ALIGN,
    S_LOCK
  } state_t;

  state_t     state, state_n;
  logic [1:0] cand, cand_n;
  logic [3:0] cnt, cnt_n;
  logic [3:0] tcnt, tcnt_n;
  logic [1:0] cfg_mode_n;
  logic       cfg_valid_n;
  logic       hv_n;
  logic       locked_n;
  logic [7:0] rc_n;
  logic       requal;
  logic       mism;

  assign mism = frame_tick && (mode_in != cfg_mode);

  // Next-state and registered-output decode
  always_comb begin
    state_n     = state;
    cand_n      = cand;
    cnt_n       = cnt;
    tcnt_n      = tcnt;
    cfg_mode_n  = cfg_mode;
    cfg_valid_n = cfg_valid;
    hv_n        = 1'b0;
    locked_n    = locked;
    rc_n        = resync_count;
    requal      = 1'b0;
    unique case (state)
      S_QUAL: begin
        if (frame_tick) begin
          if (mode_in == 2'd3 || mode_in != cand) begin
            cand_n = mode_in;
            cnt_n  = 4'd0;
          end else if (cnt + 4'd1 == SF) begin
            state_n     = S_CFG;
            cfg_mode_n  = cand;
            cfg_valid_n = 1'b1;
            cnt_n       = 4'd0;
          end else begin
            cnt_n = cnt + 4'd1;
          end
        end
      end
      S_CFG: begin
        if (cfg_valid && cfg_ready) begin
          state_n     = S_ALIGN;
          cfg_valid_n = 1'b0;
          tcnt_n      = 4'd0;
        end
      end
      S_ALIGN: begin
        if (vreset_in) begin
          hv_n     = 1'b1;
          locked_n = 1'b1;
          state_n  = S_LOCK;
        end else if (mism) begin
          requal = 1'b1;
        end else if (frame_tick) begin
          if (tcnt + 4'd1 == TF) begin
            requal = 1'b1;
          end else begin
            tcnt_n = tcnt + 4'd1;
          end
        end
      end
      S_LOCK: begin
        if (mism) begin
          locked_n = 1'b0;
          requal   = 1'b1;
        end else if (vreset_in) begin
`ifdef VIDEO_RESYNC_FORWARD_EN
          hv_n = 1'b1;
`else
          hv_n = 1'b0;
`endif
        end
      end
      default: state_n = S_QUAL;
    endcase
    if (requal) begin
      state_n = S_QUAL;
      cand_n  = mode_in;
      cnt_n   = 4'd0;
      if (resync_count != 8'hFF) begin
        rc_n = resync_count + 8'd1;
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_QUAL;
      cand         <= 2'd0;
      cnt          <= 4'd0;
      tcnt         <= 4'd0;
      cfg_mode     <= 2'd0;
      cfg_valid    <= 1'b0;
      hdmi_vreset  <= 1'b0;
      locked       <= 1'b0;
      resync_count <= 8'd0;
    end else begin
      state        <= state_n;
      cand         <= cand_n;
      cnt          <= cnt_n;
      tcnt         <= tcnt_n;
      cfg_mode     <= cfg_mode_n;
      cfg_valid    <= cfg_valid_n;
      hdmi_vreset  <= hv_n;
      locked       <= locked_n;
      resync_count <= rc_n;
    end
  end

endmodule

// File: tb/tb_video_resync_ctrl.sv
// Bench for video_resync_ctrl: vector table, corner sequences,
// and random stimulus against a frame-history reference model.
module tb_video_resync_ctrl;

  localparam int SF = 4;
  localparam int TF = 8;

  logic       clk;
  logic       reset;
  logic [1:0] mode_in;
  logic       vreset_in;
  logic       frame_tick;
  logic [1:0] cfg_mode;
  logic       cfg_valid;
  logic       cfg_ready;
  logic       hdmi_vreset;
  logic       locked;
  logic [7:0] resync_count;

  int total = 0;
  int bad   = 0;

  video_resync_ctrl #(
    .STABLE_FRAMES (SF),
    .TIMEOUT_FRAMES(TF)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .mode_in     (mode_in),
    .vreset_in   (vreset_in),
    .frame_tick  (frame_tick),
    .cfg_mode    (cfg_mode),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .hdmi_vreset (hdmi_vreset),
    .locked      (locked),
    .resync_count(resync_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: phase name plus history of frame modes
  localparam int P_QUAL  = 0;
  localparam int P_CFG   = 1;
  localparam int P_ALIGN = 2;
  localparam int P_LOCK  = 3;

  int         ph      = P_QUAL;
  logic [1:0] hist[$] = '{2'd0};
  int         waited  = 0;
  logic [1:0] m_mode  = 2'd0;
  logic       m_valid = 1'b0;
  logic       m_hv    = 1'b0;
  logic       m_lock  = 1'b0;
  int         m_cnt   = 0;

  task automatic requal();
    ph = P_QUAL;
    hist = '{mode_in};
    m_cnt = (m_cnt >= 255) ? 255 : m_cnt + 1;
  endtask

  function automatic bit hist_ok();
    if (hist.size() != SF + 1) return 1'b0;
    if (hist[0] == 2'd3) return 1'b0;
    foreach (hist[i]) if (hist[i] != hist[0]) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    m_hv = 1'b0;
    if (reset) begin
      ph = P_QUAL;
      hist = '{2'd0};
      waited = 0;
      m_mode = 2'd0;
      m_valid = 1'b0;
      m_lock = 1'b0;
      m_cnt = 0;
    end else begin
      case (ph)
        P_QUAL: if (frame_tick) begin
          hist.push_back(mode_in);
          if (hist.size() > SF + 1) void'(hist.pop_front());
          if (hist_ok()) begin
            ph = P_CFG;
            m_mode = hist[0];
            m_valid = 1'b1;
            hist.delete();
          end
        end
        P_CFG: if (cfg_ready) begin
          m_valid = 1'b0;
          ph = P_ALIGN;
          waited = 0;
        end
        P_ALIGN: begin
          if (vreset_in) begin
            m_hv = 1'b1;
            m_lock = 1'b1;
            ph = P_LOCK;
          end else if (frame_tick) begin
            if (mode_in != m_mode) requal();
            else begin
              waited++;
              if (waited == TF) requal();
            end
          end
        end
        default: begin
          if (frame_tick && mode_in != m_mode) begin
            m_lock = 1'b0;
            requal();
          end else if (vreset_in) begin
`ifdef VIDEO_RESYNC_FORWARD_EN
            m_hv = 1'b1;
`endif
          end
        end
      endcase
    end
    #2;
    total++;
    if ({cfg_mode, cfg_valid, hdmi_vreset, locked, resync_count} !==
        {m_mode, m_valid, m_hv, m_lock, 8'(m_cnt)}) begin
      bad++;
      $display("FAIL model t=%0t got=%h want=%h", $time,
        {cfg_mode, cfg_valid, hdmi_vreset, locked, resync_count},
        {m_mode, m_valid, m_hv, m_lock, 8'(m_cnt)});
    end
  end

  task automatic cyc(input logic r, input logic [1:0] m, input logic v,
                     input logic f, input logic rd);
    @(negedge clk);
    reset = r;
    mode_in = m;
    vreset_in = v;
    frame_tick = f;
    cfg_ready = rd;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic lock_mode(input logic [1:0] m);
    repeat (SF + 1) cyc(0, m, 0, 1, 1);
    cyc(0, m, 0, 0, 1);
    cyc(0, m, 1, 0, 1);
  endtask

  typedef struct {
    logic       r;
    logic [1:0] m;
    logic       v;
    logic       f;
    logic       rd;
    logic [1:0] em;
    logic       ev;
    logic       eh;
    logic       el;
    logic [7:0] ec;
  } vec_t;

  vec_t tbl[14];

  initial begin
    int hv;
    logic [1:0] rm;
    logic [1:0] sm;
    reset = 1'b1;
    mode_in = 2'd0;
    vreset_in = 1'b0;
    frame_tick = 1'b0;
    cfg_ready = 1'b0;

    tbl[0]  = '{1'b1, 2'd1, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[1]  = '{1'b0, 2'd1, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[2]  = '{1'b0, 2'd1, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[3]  = '{1'b0, 2'd1, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[4]  = '{1'b0, 2'd1, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[5]  = '{1'b0, 2'd1, 1'b0, 1'b1, 1'b1, 2'd1, 1'b1, 1'b0, 1'b0, 8'd0};
    tbl[6]  = '{1'b0, 2'd1, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[7]  = '{1'b0, 2'd1, 1'b0, 1'b1, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[8]  = '{1'b0, 2'd1, 1'b0, 1'b1, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[9]  = '{1'b0, 2'd1, 1'b0, 1'b1, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[10] = '{1'b0, 2'd1, 1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 1'b1, 1'b1, 8'd0};
    tbl[11] = '{1'b0, 2'd1, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b1, 8'd0};
    tbl[12] = '{1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 8'd1};
    tbl[13] = '{1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 8'd1};

    // PAL lock and lock loss via vector table
    for (int i = 0; i < 14; i++) begin
      cyc(tbl[i].r, tbl[i].m, tbl[i].v, tbl[i].f, tbl[i].rd);
      chk($sformatf("vec%0d", i),
          {19'd0, cfg_mode, cfg_valid, hdmi_vreset, locked, resync_count},
          {19'd0, tbl[i].em, tbl[i].ev, tbl[i].eh, tbl[i].el, tbl[i].ec});
    end

    // Unstable mode never qualifies
    cyc(1, 0, 0, 0, 1);
    hv = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(0, 2'(i % 2), 0, 1, 1);
      hv += int'(cfg_valid);
    end
    repeat (3) begin
      cyc(0, 3, 0, 1, 1);
      hv += int'(cfg_valid);
    end
    chk("unstable_valid", hv, 0);
    chk("unstable_lock", locked, 0);

    // Backpressure: request held while mode changes
    cyc(1, 0, 0, 0, 0);
    repeat (SF) cyc(0, 0, 0, 1, 0);
    chk("bp_valid_rise", cfg_valid, 1);
    hv = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(0, (i < 5) ? 2'd0 : 2'd1, 0, (i % 4) == 0, 0);
      if (cfg_valid !== 1'b1 || cfg_mode !== 2'd0) hv++;
    end
    chk("bp_hold", hv, 0);
    cyc(0, 1, 0, 0, 1);
    chk("bp_handshake", cfg_valid, 0);
    cyc(0, 1, 0, 1, 0);
    chk("bp_resync", resync_count, 1);
    repeat (SF) cyc(0, 1, 0, 1, 0);
    chk("bp_requal", {cfg_valid, cfg_mode}, 3'b101);

    // Align timeout
    cyc(1, 0, 0, 0, 1);
    repeat (SF) cyc(0, 0, 0, 1, 1);
    hv = 0;
    cyc(0, 0, 0, 0, 1);
    chk("to_hs", cfg_valid, 0);
    for (int i = 0; i < TF; i++) begin
      cyc(0, 0, 0, 1, 1);
      hv += int'(hdmi_vreset);
      if (i == TF - 2) chk("to_early", resync_count, 0);
    end
    chk("to_count", resync_count, 1);
    chk("to_no_pulse", hv, 0);
    repeat (SF) cyc(0, 0, 0, 1, 1);
    chk("to_requal", cfg_valid, 1);

    // Lock loss then async reset during CONFIG
    cyc(1, 0, 0, 0, 1);
    lock_mode(1);
    chk("ll_locked", locked, 1);
    cyc(0, 0, 0, 1, 1);
    chk("ll_drop", {locked, resync_count}, 9'h001);
    repeat (SF) cyc(0, 0, 0, 1, 0);
    chk("ll_cfg", {cfg_valid, cfg_mode}, 3'b100);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_async", {cfg_valid, cfg_mode, locked, resync_count}, 12'd0);
    cyc(1, 0, 0, 0, 0);

    // Forwarding while locked
    cyc(1, 1, 0, 0, 1);
    lock_mode(1);
    hv = 0;
    repeat (3) begin
      cyc(0, 1, 1, 0, 1);
      hv += int'(hdmi_vreset);
      cyc(0, 1, 0, 0, 1);
      hv += int'(hdmi_vreset);
      cyc(0, 1, 0, 1, 1);
      hv += int'(hdmi_vreset);
    end
`ifdef VIDEO_RESYNC_FORWARD_EN
    chk("fwd_pulses", hv, 3);
`else
    chk("fwd_pulses", hv, 0);
`endif
    chk("fwd_locked", locked, 1);

    // Saturation of resync_count
    cyc(1, 0, 0, 0, 1);
    sm = 2'd1;
    for (int i = 0; i < 260; i++) begin
      repeat (SF + 1) cyc(0, sm, 0, 1, 1);
      cyc(0, sm, 0, 0, 1);
      cyc(0, ~sm, 0, 1, 1);
      sm = ~sm;
      if (i == 253) chk("sat_254", resync_count, 254);
    end
    chk("sat_255", resync_count, 255);

    // Random stimulus against the model
    cyc(1, 0, 0, 0, 0);
    rm = 2'd1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 39) == 0) rm = 2'($urandom_range(0, 3));
      cyc($urandom_range(0, 799) == 0, rm,
          $urandom_range(0, 11) == 0,
          $urandom_range(0, 5) == 0,
          $urandom_range(0, 1) == 0);
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
